// File: rtl/mc_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller_pkg
// Brief    : Shared opcodes, funct codes, ALU op codes, ALU-op classes and
//            FSM state encoding for the multicycle MIPS control unit.
// Revision : 1.0 - initial release
// ============================================================================
package mc_controller_pkg;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU operation codes driven onto alucontrol
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_NONE = 3'b011;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // ALU operation class chosen by the FSM
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // FSM state encoding; 12..15 are unused and recover to FETCH
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_EXECUTE = 4'd6,
    ST_ALUWB   = 4'd7,
    ST_BRANCH  = 4'd8,
    ST_ADDIEX  = 4'd9,
    ST_ADDIWB  = 4'd10,
    ST_JUMP    = 4'd11
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mc_controller_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller_alu_decoder
// Brief    : Combinational ALU decoder: (aluop, funct) -> alucontrol.
// Revision : 1.0 - initial release
// ============================================================================
module mc_controller_alu_decoder
  import mc_controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Fixed add/sub for address and branch work; otherwise decode the funct field
  always_comb begin
    alucontrol = ALU_NONE;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      default: begin
        case (funct)
          FUNCT_ADD: alucontrol = ALU_ADD;
          FUNCT_SUB: alucontrol = ALU_SUB;
          FUNCT_AND: alucontrol = ALU_AND;
          FUNCT_OR:  alucontrol = ALU_OR;
          FUNCT_SLT: alucontrol = ALU_SLT;
          default:   alucontrol = ALU_NONE;
        endcase
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : mc_controller
// Brief    : Multicycle MIPS control unit. Moore FSM sequencing each
//            instruction, issuing datapath mux selects, write enables and
//            the ALU operation code.
// Revision : 1.0 - initial release
// ============================================================================
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alucontrol,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic [1:0] pcsrc,
  output logic       irwrite,
  output logic       memwrite,
  output logic       regwrite,
  output logic       pcen
);

  state_t     state;
  state_t     state_next;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;
  logic       irwrite_st;
  logic       memwrite_st;
  logic       regwrite_st;

  // State register; reset forces FETCH immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_next;
  end

  // Next-state and per-state (Moore) control outputs
  always_comb begin
    state_next  = ST_FETCH;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    iord        = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    pcsrc       = 2'b00;
    irwrite_st  = 1'b0;
    memwrite_st = 1'b0;
    regwrite_st = 1'b0;
    pcwrite     = 1'b0;
    branch      = 1'b0;
    aluop       = ALUOP_ADD;
    case (state)
      ST_FETCH: begin
        alusrcb    = 2'b01;
        irwrite_st = 1'b1;
        pcwrite    = 1'b1;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        // ALU precomputes the branch target while op is decoded
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_next = ST_MEMADR;
          OP_RTYPE:     state_next = ST_EXECUTE;
          OP_BEQ:       state_next = ST_BRANCH;
          OP_ADDI:      state_next = ST_ADDIEX;
          OP_J:         state_next = ST_JUMP;
          default:      state_next = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        iord       = 1'b1;
        state_next = ST_MEMWB;
      end
      ST_MEMWB: begin
        memtoreg    = 1'b1;
        regwrite_st = 1'b1;
      end
      ST_MEMWR: begin
        iord        = 1'b1;
        memwrite_st = 1'b1;
      end
      ST_EXECUTE: begin
        alusrca    = 1'b1;
        aluop      = ALUOP_FUNCT;
        state_next = ST_ALUWB;
      end
      ST_ALUWB: begin
        regdst      = 1'b1;
        regwrite_st = 1'b1;
      end
      ST_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ST_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = ST_ADDIWB;
      end
      ST_ADDIWB: begin
        regwrite_st = 1'b1;
      end
      ST_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_next = ST_FETCH;
    endcase
  end

  // Write enables are suppressed combinationally for as long as reset is high
  assign irwrite  = irwrite_st  & ~reset;
  assign memwrite = memwrite_st & ~reset;
  assign regwrite = regwrite_st & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;

  mc_controller_alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_controller
// Brief    : Directed self-checking bench for mc_controller. Outputs are
//            packed into one vector and compared per cycle against
//            hand-derived per-state values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic [2:0] alucontrol;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] pcsrc;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       pcen;
  logic [14:0] obs;

  int checks = 0;
  int errors = 0;

  // Packing: alucontrol[14:12] alusrca[11] alusrcb[10:9] iord[8] memtoreg[7]
  //          regdst[6] pcsrc[5:4] irwrite[3] memwrite[2] regwrite[1] pcen[0]
  localparam logic [14:0] V_RESET   = 15'b010_0_01_0_0_0_00_0000;
  localparam logic [14:0] V_FETCH   = 15'b010_0_01_0_0_0_00_1001;
  localparam logic [14:0] V_DECODE  = 15'b010_0_11_0_0_0_00_0000;
  localparam logic [14:0] V_MEMADR  = 15'b010_1_10_0_0_0_00_0000;
  localparam logic [14:0] V_MEMRD   = 15'b010_0_00_1_0_0_00_0000;
  localparam logic [14:0] V_MEMWB   = 15'b010_0_00_0_1_0_00_0010;
  localparam logic [14:0] V_MEMWR   = 15'b010_0_00_1_0_0_00_0100;
  localparam logic [14:0] V_EXE_SUB = 15'b110_1_00_0_0_0_00_0000;
  localparam logic [14:0] V_EXE_SLT = 15'b111_1_00_0_0_0_00_0000;
  localparam logic [14:0] V_EXE_BAD = 15'b011_1_00_0_0_0_00_0000;
  localparam logic [14:0] V_ALUWB   = 15'b010_0_00_0_0_1_00_0010;
  localparam logic [14:0] V_BR_Z1   = 15'b110_1_00_0_0_0_01_0001;
  localparam logic [14:0] V_BR_Z0   = 15'b110_1_00_0_0_0_01_0000;
  localparam logic [14:0] V_ADDIEX  = 15'b010_1_10_0_0_0_00_0000;
  localparam logic [14:0] V_ADDIWB  = 15'b010_0_00_0_0_0_00_0010;
  localparam logic [14:0] V_JUMP    = 15'b010_0_00_0_0_0_10_0001;

  always #5 clk = ~clk;

  assign obs = {alucontrol, alusrca, alusrcb, iord, memtoreg, regdst,
                pcsrc, irwrite, memwrite, regwrite, pcen};

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .alucontrol (alucontrol),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .iord       (iord),
    .memtoreg   (memtoreg),
    .regdst     (regdst),
    .pcsrc      (pcsrc),
    .irwrite    (irwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .pcen       (pcen)
  );

  // Advance to just after the next falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op    = 6'b100011;
    funct = 6'b000000;
    zero  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== V_RESET) begin
        errors++;
        $display("FAIL reset cyc%0d: got %b expected %b", i, obs, V_RESET);
      end
    end
  endtask

  task automatic test_lw();
    logic [14:0] exp [0:5];
    exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCH};
    op    = 6'b100011;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL lw cyc%0d: got %b expected %b", i, obs, exp[i]);
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0]  fl [0:2];
    logic [14:0] ev [0:2];
    logic [14:0] exp [0:4];
    fl = '{6'b100010, 6'b101010, 6'b111111};
    ev = '{V_EXE_SUB, V_EXE_SLT, V_EXE_BAD};
    for (int k = 0; k < 3; k++) begin
      op    = 6'b000000;
      funct = fl[k];
      #1;
      exp = '{V_FETCH, V_DECODE, ev[k], V_ALUWB, V_FETCH};
      for (int i = 0; i < 5; i++) begin
        if (i > 0) tick();
        checks++;
        if (obs !== exp[i]) begin
          errors++;
          $display("FAIL rtype f=%b cyc%0d: got %b expected %b", fl[k], i, obs, exp[i]);
        end
      end
    end
  endtask

  task automatic test_beq();
    logic [14:0] exp [0:3];
    for (int k = 0; k < 2; k++) begin
      op   = 6'b000100;
      zero = (k == 0);
      #1;
      exp = '{V_FETCH, V_DECODE, (k == 0) ? V_BR_Z1 : V_BR_Z0, V_FETCH};
      for (int i = 0; i < 4; i++) begin
        if (i > 0) tick();
        checks++;
        if (obs !== exp[i]) begin
          errors++;
          $display("FAIL beq z=%0d cyc%0d: got %b expected %b", zero, i, obs, exp[i]);
        end
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_sw_addi_j();
    logic [14:0] exp_sw [0:4];
    logic [14:0] exp_ad [0:4];
    logic [14:0] exp_j  [0:3];
    exp_sw = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR, V_FETCH};
    exp_ad = '{V_FETCH, V_DECODE, V_ADDIEX, V_ADDIWB, V_FETCH};
    exp_j  = '{V_FETCH, V_DECODE, V_JUMP, V_FETCH};
    op = 6'b101011;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp_sw[i]) begin
        errors++;
        $display("FAIL sw cyc%0d: got %b expected %b", i, obs, exp_sw[i]);
      end
    end
    op = 6'b001000;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp_ad[i]) begin
        errors++;
        $display("FAIL addi cyc%0d: got %b expected %b", i, obs, exp_ad[i]);
      end
    end
    op = 6'b000010;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp_j[i]) begin
        errors++;
        $display("FAIL j cyc%0d: got %b expected %b", i, obs, exp_j[i]);
      end
    end
  endtask

  task automatic test_unknown_op();
    logic [14:0] exp [0:4];
    exp = '{V_FETCH, V_DECODE, V_FETCH, V_DECODE, V_FETCH};
    op   = 6'b111111;
    zero = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL nop cyc%0d: got %b expected %b", i, obs, exp[i]);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_reset_midway();
    logic [14:0] exp_sw [0:3];
    logic [14:0] exp_ad [0:4];
    exp_sw = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR};
    exp_ad = '{V_FETCH, V_DECODE, V_ADDIEX, V_ADDIWB, V_FETCH};
    op = 6'b101011;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp_sw[i]) begin
        errors++;
        $display("FAIL midrst sw cyc%0d: got %b expected %b", i, obs, exp_sw[i]);
      end
    end
    // Assert reset inside MEMWR: the write must vanish in the same cycle
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== V_RESET) begin
      errors++;
      $display("FAIL midrst assert: got %b expected %b", obs, V_RESET);
    end
    tick();
    checks++;
    if (obs !== V_RESET) begin
      errors++;
      $display("FAIL midrst held: got %b expected %b", obs, V_RESET);
    end
    reset = 1'b0;
    op    = 6'b001000;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (obs !== exp_ad[i]) begin
        errors++;
        $display("FAIL midrst addi cyc%0d: got %b expected %b", i, obs, exp_ad[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_sw_addi_j();
    test_unknown_op();
    test_reset_midway();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stalled run
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
